// File: rtl/egress_tlp_arb.sv
// egress_tlp_arb: packet-granular arbiter sharing the PCIe TX AXI-Stream link
// between the completion (cpl), write-request (wr) and read-request (rd)
// engines. A granted source owns the link from sop to eop. A one-entry
// registered output stage isolates link backpressure from the sources.
module egress_tlp_arb #(
  parameter int DATA_W   = 128,
  parameter int KEEP_W   = 16,
  parameter int CPL_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_cpl_tdata,
  input  logic [KEEP_W-1:0] s_cpl_tkeep,
  input  logic              s_cpl_sop,
  input  logic              s_cpl_eop,
  input  logic              s_cpl_tvalid,
  output logic              s_cpl_tready,
  input  logic [DATA_W-1:0] s_wr_tdata,
  input  logic [KEEP_W-1:0] s_wr_tkeep,
  input  logic              s_wr_sop,
  input  logic              s_wr_eop,
  input  logic              s_wr_tvalid,
  output logic              s_wr_tready,
  input  logic [DATA_W-1:0] s_rd_tdata,
  input  logic [KEEP_W-1:0] s_rd_tkeep,
  input  logic              s_rd_sop,
  input  logic              s_rd_eop,
  input  logic              s_rd_tvalid,
  output logic              s_rd_tready,
  output logic [DATA_W-1:0] m_axis_tx_tdata,
  output logic [KEEP_W-1:0] m_axis_tx_tkeep,
  output logic              m_axis_tx_sop,
  output logic              m_axis_tx_eop,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready,
  output logic [2:0]        grant,
  output logic              err_orphan
);
  localparam int NSRC = 3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state, state_nxt;

  // Sources packed as index 0=cpl, 1=wr, 2=rd (same order as grant bits).
  logic [NSRC-1:0][DATA_W-1:0] src_data;
  logic [NSRC-1:0][KEEP_W-1:0] src_keep;
  logic [NSRC-1:0]             src_sop, src_eop, src_vld, src_rdy;
  logic [NSRC-1:0]             src_req, src_orph;

  logic [1:0]        rr_ptr, win_idx;
  logic [2:0]        pos;
  logic              win_any, acc, out_valid;
  logic [DATA_W-1:0] beat_data;
  logic [KEEP_W-1:0] beat_keep;
  logic              beat_sop, beat_eop;

  assign src_data = {s_rd_tdata, s_wr_tdata, s_cpl_tdata};
  assign src_keep = {s_rd_tkeep, s_wr_tkeep, s_cpl_tkeep};
  assign src_sop  = {s_rd_sop, s_wr_sop, s_cpl_sop};
  assign src_eop  = {s_rd_eop, s_wr_eop, s_cpl_eop};
  assign src_vld  = {s_rd_tvalid, s_wr_tvalid, s_cpl_tvalid};
  assign {s_rd_tready, s_wr_tready, s_cpl_tready} = src_rdy;

  assign src_req  = src_vld & src_sop;
  assign src_orph = src_vld & ~src_sop;

  // Ready: in IDLE only orphan beats are drained; in BUSY only the owner
  // advances, and only while the output register can take a beat.
  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_rdy
      assign src_rdy[i] = !rst && ((state == IDLE) ? src_orph[i]
                        : (grant[i] && (!out_valid || m_axis_tx_tready)));
    end
  endgenerate

  // Winner pick: optional strict cpl priority, else round-robin from rr_ptr
  // (cpl is skipped in the rotation when it has strict priority).
  always_comb begin
    win_any = 1'b0;
    win_idx = 2'd0;
    pos     = 3'd0;
    if (CPL_PRIO != 0 && src_req[0]) begin
      win_any = 1'b1;
      win_idx = 2'd0;
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        pos = {1'b0, rr_ptr} + 3'(k);
        if (pos >= 3'd3) pos = pos - 3'd3;
        if (!win_any && src_req[pos[1:0]] && !(CPL_PRIO != 0 && pos == 3'd0)) begin
          win_any = 1'b1;
          win_idx = pos[1:0];
        end
      end
    end
  end

  // Beat mux from the one-hot owner.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    beat_sop  = 1'b0;
    beat_eop  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        beat_data = src_data[i];
        beat_keep = src_keep[i];
        beat_sop  = src_sop[i];
        beat_eop  = src_eop[i];
      end
    end
  end

  assign acc = (state == BUSY) && |(src_vld & src_rdy);

  // Next state: one IDLE bubble per packet, leave BUSY on accepted eop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_any) state_nxt = BUSY;
      BUSY:    if (acc && beat_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_any) begin
        grant  <= 3'b001 << win_idx;
        rr_ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      end else if (acc && beat_eop) begin
        grant <= '0;
      end
      if (state == IDLE && |src_orph) err_orphan <= 1'b1;
    end
  end

  // Output register: load wins over drain so back-to-back beats stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      m_axis_tx_tdata <= '0;
      m_axis_tx_tkeep <= '0;
      m_axis_tx_sop   <= 1'b0;
      m_axis_tx_eop   <= 1'b0;
    end else if (acc) begin
      out_valid       <= 1'b1;
      m_axis_tx_tdata <= beat_data;
      m_axis_tx_tkeep <= beat_keep;
      m_axis_tx_sop   <= beat_sop;
      m_axis_tx_eop   <= beat_eop;
    end else if (out_valid && m_axis_tx_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign m_axis_tx_tvalid = out_valid;

endmodule

// File: tb/tb_egress_tlp_arb.sv
// Bench for egress_tlp_arb: two instances (round-robin and cpl-priority)
// driven by independent AXIS source generators, checked every cycle against
// a transaction-level reference (owner id, pointer, one-slot output queue).
module tb_egress_tlp_arb;
  localparam int DW = 32;
  localparam int KW = 4;

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  logic [DW-1:0] sd [2][3];
  logic [KW-1:0] sk [2][3];
  logic          ssop [2][3], seop [2][3], svld [2][3], srdy [2][3];
  logic [DW-1:0] md [2];
  logic [KW-1:0] mk [2];
  logic          msop [2], meop [2], mvld [2], mrdy [2], merr_o [2];
  logic [2:0]    gnt [2];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      egress_tlp_arb #(.DATA_W(DW), .KEEP_W(KW), .CPL_PRIO(g)) u_dut (
        .clk(gclk), .rst(rst),
        .s_cpl_tdata(sd[g][0]), .s_cpl_tkeep(sk[g][0]), .s_cpl_sop(ssop[g][0]),
        .s_cpl_eop(seop[g][0]), .s_cpl_tvalid(svld[g][0]), .s_cpl_tready(srdy[g][0]),
        .s_wr_tdata(sd[g][1]), .s_wr_tkeep(sk[g][1]), .s_wr_sop(ssop[g][1]),
        .s_wr_eop(seop[g][1]), .s_wr_tvalid(svld[g][1]), .s_wr_tready(srdy[g][1]),
        .s_rd_tdata(sd[g][2]), .s_rd_tkeep(sk[g][2]), .s_rd_sop(ssop[g][2]),
        .s_rd_eop(seop[g][2]), .s_rd_tvalid(svld[g][2]), .s_rd_tready(srdy[g][2]),
        .m_axis_tx_tdata(md[g]), .m_axis_tx_tkeep(mk[g]), .m_axis_tx_sop(msop[g]),
        .m_axis_tx_eop(meop[g]), .m_axis_tx_tvalid(mvld[g]), .m_axis_tx_tready(mrdy[g]),
        .grant(gnt[g]), .err_orphan(merr_o[g])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  // source generator state
  bit act [2][3], orph [2][3], hs [2][3];
  int len [2][3], idx [2][3], pkt [2][3];
  int p_new [3];
  int p_vld, p_mrdy, p_msop, max_len;

  // reference model state
  int            own [2], ptr [2], obeats [2];
  bit            ofull [2], merr [2], zchk [2];
  logic [DW-1:0] od [2];
  logic [KW-1:0] okp [2];
  bit            osop [2], oeop [2];
  int            osrc [2][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // cpl strict-priority or round-robin search from the pointer, modulo 3
  function automatic int pick(input bit [2:0] req, input int p, input bit prio);
    int j;
    if (prio && req[0]) return 0;
    for (int k = 0; k < 3; k++) begin
      j = (p + k) % 3;
      if (req[j] && !(prio && j == 0)) return j;
    end
    return -1;
  endfunction

  task automatic present(input int d, input int s);
    sd[d][s]   = {4'(d), 4'(s), 16'(pkt[d][s]), 8'(idx[d][s])};
    sk[d][s]   = (idx[d][s] == len[d][s] - 1) ? KW'($urandom_range(15, 1)) : '1;
    ssop[d][s] = (idx[d][s] == 0) || ($urandom_range(99) < p_msop);
    seop[d][s] = (idx[d][s] == len[d][s] - 1);
    svld[d][s] = 1'b1;
  endtask

  task automatic start_pkt(input int d, input int s, input int l);
    act[d][s] = 1'b1;
    len[d][s] = l;
    idx[d][s] = 0;
    present(d, s);
  endtask

  // source/link drivers, run just after the active edge
  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) begin
        if (rst) begin
          svld[d][s] = 1'b0; act[d][s] = 1'b0; orph[d][s] = 1'b0;
        end else begin
          if (hs[d][s]) begin
            svld[d][s] = 1'b0;
            if (orph[d][s]) orph[d][s] = 1'b0;
            else begin
              idx[d][s]++;
              if (idx[d][s] == len[d][s]) begin act[d][s] = 1'b0; pkt[d][s]++; end
            end
          end
          if (!svld[d][s]) begin
            if (act[d][s] && $urandom_range(99) < p_vld) present(d, s);
            else if (!act[d][s] && !orph[d][s] && $urandom_range(99) < p_new[s])
              start_pkt(d, s, int'($urandom_range(max_len, 1)));
          end
        end
      end
      mrdy[d] = ($urandom_range(99) < p_mrdy);
    end
  endtask

  // one cycle: check at negedge, advance model, then drive after posedge
  task automatic step();
    logic [2:0] egr, erdy, ardy;
    bit   [2:0] req;
    int         a, w;
    @(negedge gclk);
    for (int d = 0; d < 2; d++) begin
      egr = (own[d] < 0) ? 3'b000 : 3'(1 << own[d]);
      for (int s = 0; s < 3; s++) begin
        if (rst)           erdy[s] = 1'b0;
        else if (own[d] < 0) erdy[s] = svld[d][s] && !ssop[d][s];
        else               erdy[s] = (s == own[d]) && (!ofull[d] || mrdy[d]);
        ardy[s]  = srdy[d][s];
        hs[d][s] = svld[d][s] && srdy[d][s];
      end
      chk($sformatf("d%0d grant", d), 64'(gnt[d]), 64'(egr));
      chk($sformatf("d%0d tready", d), 64'(ardy), 64'(erdy));
      chk($sformatf("d%0d tvalid", d), 64'(mvld[d]), 64'(ofull[d]));
      chk($sformatf("d%0d err_orphan", d), 64'(merr_o[d]), 64'(merr[d]));
      if (ofull[d]) begin
        chk($sformatf("d%0d tdata", d), 64'(md[d]), 64'(od[d]));
        chk($sformatf("d%0d tkeep", d), 64'(mk[d]), 64'(okp[d]));
        chk($sformatf("d%0d sop", d), 64'(msop[d]), 64'(osop[d]));
        chk($sformatf("d%0d eop", d), 64'(meop[d]), 64'(oeop[d]));
      end
      if (zchk[d]) begin
        chk($sformatf("d%0d rst_out", d), {md[d], 24'(mk[d]), 7'(msop[d]), meop[d]}, 64'd0);
        zchk[d] = 1'b0;
      end
      if (mvld[d] && mrdy[d]) begin
        obeats[d]++;
        if (msop[d]) osrc[d].push_back(int'(md[d][27:24]));
      end
      // model advance
      if (rst) begin
        own[d] = -1; ptr[d] = 0; ofull[d] = 1'b0; merr[d] = 1'b0; zchk[d] = 1'b1;
      end else begin
        a = -1;
        if (own[d] >= 0 && svld[d][own[d]] && erdy[own[d]]) a = own[d];
        if (own[d] < 0) begin
          for (int s = 0; s < 3; s++) begin
            if (svld[d][s] && !ssop[d][s]) merr[d] = 1'b1;
            req[s] = svld[d][s] && ssop[d][s];
          end
          w = pick(req, ptr[d], d == 1);
          if (w >= 0) begin own[d] = w; ptr[d] = (w + 1) % 3; end
        end else if (a >= 0 && seop[d][a]) begin
          own[d] = -1;
        end
        if (a >= 0) begin
          ofull[d] = 1'b1; od[d] = sd[d][a]; okp[d] = sk[d][a];
          osop[d] = ssop[d][a]; oeop[d] = seop[d][a];
        end else if (ofull[d] && mrdy[d]) begin
          ofull[d] = 1'b0;
        end
      end
    end
    @(posedge gclk);
    #1;
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic set_mode(input int pc, input int pw, input int pr, input int ml,
                          input int pv, input int pm, input int ps);
    p_new[0] = pc; p_new[1] = pw; p_new[2] = pr;
    max_len = ml; p_vld = pv; p_mrdy = pm; p_msop = ps;
  endtask

  task automatic drain();
    bit idle;
    set_mode(0, 0, 0, 1, 100, 100, 0);
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      step();
      idle = 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (own[d] >= 0 || ofull[d]) idle = 1'b0;
        for (int s = 0; s < 3; s++) if (act[d][s] || svld[d][s]) idle = 1'b0;
      end
    end
    chk("drain_timeout", 64'(idle), 64'd1);
  endtask

  initial begin
    int pat [6] = '{1, 0, 0, 1, 1, 1};
    int b0, b1;
    bit reached;
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; ptr[d] = 0; ofull[d] = 1'b0; merr[d] = 1'b0; zchk[d] = 1'b0;
      obeats[d] = 0; mrdy[d] = 1'b0;
      for (int s = 0; s < 3; s++) begin
        sd[d][s] = '0; sk[d][s] = '0; ssop[d][s] = 1'b0; seop[d][s] = 1'b0;
        svld[d][s] = 1'b0; act[d][s] = 1'b0; orph[d][s] = 1'b0; hs[d][s] = 1'b0;
        len[d][s] = 1; idx[d][s] = 0; pkt[d][s] = 0;
      end
    end
    set_mode(0, 0, 0, 1, 100, 100, 0);
    repeat (2) @(posedge gclk);
    #1;
    do_reset(3);

    // orphan beat on wr while idle: drained, not forwarded, sticky error
    for (int d = 0; d < 2; d++) begin
      sd[d][1] = 32'hA5A5_A5A5; sk[d][1] = '1; ssop[d][1] = 1'b0; seop[d][1] = 1'b0;
      svld[d][1] = 1'b1; orph[d][1] = 1'b1;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d orphan_err", d), 64'(merr_o[d]), 64'd1);
      chk($sformatf("d%0d orphan_nofwd", d), 64'(obeats[d]), 64'd0);
    end

    // single 3-beat wr TLP
    for (int d = 0; d < 2; d++) start_pkt(d, 1, 3);
    repeat (8) step();
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d wr3_beats", d), 64'(obeats[d]), 64'd3);

    // 4-beat rd TLP under a stalling link
    b0 = obeats[0]; b1 = obeats[1];
    for (int d = 0; d < 2; d++) start_pkt(d, 2, 4);
    for (int i = 0; i < 6; i++) begin
      p_mrdy = pat[i] ? 100 : 0;
      step();
    end
    p_mrdy = 100;
    repeat (6) step();
    chk("d0 rd4_beats", 64'(obeats[0] - b0), 64'd4);
    chk("d1 rd4_beats", 64'(obeats[1] - b1), 64'd4);
    chk("d0 err_held", 64'(merr_o[0]), 64'd1);

    // all three sources streaming 1-beat TLPs right after reset
    do_reset(1);
    osrc[0].delete(); osrc[1].delete();
    set_mode(100, 100, 100, 1, 100, 100, 0);
    repeat (20) step();
    chk("rr_count", 64'(osrc[0].size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < osrc[0].size(); i++)
      chk($sformatf("rr_order%0d", i), 64'(osrc[0][i]), 64'(i % 3));
    for (int i = 0; i < osrc[1].size(); i++)
      chk($sformatf("prio_cpl%0d", i), 64'(osrc[1][i]), 64'd0);

    // cpl bursty, wr/rd always pending
    set_mode(40, 100, 100, 2, 100, 100, 0);
    repeat (200) step();

    // fully random traffic with stalls, gaps and mid-packet sop
    set_mode(30, 30, 30, 4, 80, 60, 10);
    repeat (2000) step();

    // reset in the middle of a 4-beat cpl TLP
    drain();
    set_mode(0, 0, 0, 1, 100, 100, 0);
    for (int d = 0; d < 2; d++) start_pkt(d, 0, 4);
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      step();
      reached = (idx[0][0] == 2);
    end
    chk("rst_mid_reach", 64'(reached), 64'd1);
    do_reset(1);
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst_grant", d), 64'(gnt[d]), 64'd0);
      chk($sformatf("d%0d rst_valid", d), 64'(mvld[d]), 64'd0);
    end
    b0 = obeats[0]; b1 = obeats[1];
    for (int d = 0; d < 2; d++) start_pkt(d, 1, 2);
    repeat (8) step();
    chk("d0 post_rst_wr", 64'(obeats[0] - b0), 64'd2);
    chk("d1 post_rst_wr", 64'(obeats[1] - b1), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/egress_tlp_arb.md
Name: egress_tlp_arb

Overview:
- Packet-granular arbiter that shares the single PCIe TX AXI-Stream link between three TLP sources: completion engine, write-request engine and read-request engine.
- Sits in the egress path, mirroring the ingress split into cpl/wrreq/rdreq streams, and feeds the core's s_axis_tx interface.
- Once granted, a source keeps the link from sop to eop; a one-entry registered output stage isolates link backpressure.

Parameters:
- DATA_W, 128, TLP beat width (matches PCIE_DATA_WIDTH).
- KEEP_W, 16, byte-keep width (matches PCIE_DATA_KW).
- CPL_PRIO, 1, 1 = completions strictly win arbitration; 0 = pure round-robin over all three sources.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- s_{cpl,wr,rd}_tdata  in  DATA_W  per-source beat data.
- s_{cpl,wr,rd}_tkeep  in  KEEP_W  per-source byte keep.
- s_{cpl,wr,rd}_sop  in  1  first beat of TLP.
- s_{cpl,wr,rd}_eop  in  1  last beat of TLP.
- s_{cpl,wr,rd}_tvalid  in  1  beat valid.
- s_{cpl,wr,rd}_tready  out  1  beat accepted when tvalid&&tready.
- m_axis_tx_tdata  out  DATA_W  link beat data.
- m_axis_tx_tkeep  out  KEEP_W  link byte keep.
- m_axis_tx_sop  out  1  link sop.
- m_axis_tx_eop  out  1  link eop.
- m_axis_tx_tvalid  out  1  link valid.
- m_axis_tx_tready  in  1  link ready.
- grant  out  3  one-hot current owner, bit order {rd,wr,cpl}.
- err_orphan  out  1  sticky: beat without sop seen at a source while it had no grant.

Behaviour:
- Reset: every output is 0: m_axis_tx_*, all s_*_tready, grant and err_orphan. State goes to IDLE and the RR pointer to cpl. Reset mid-packet abandons the packet with no eop emitted.
- Request: src_req[i] = s_i_tvalid && s_i_sop.
- State IDLE:
  - All s_*_tready = 0, except orphan drain (below).
  - If any src_req, register the winner into grant and go to BUSY next cycle. This costs exactly one arbitration bubble per packet.
- Winner selection:
  - CPL_PRIO=1: cpl wins whenever it requests; otherwise round-robin between wr and rd.
  - CPL_PRIO=0: round-robin over cpl, wr, rd, starting from the pointer.
  - The pointer advances to winner+1 (mod 3) on each grant.
- State BUSY:
  - s_g_tready = !out_valid || m_axis_tx_tready (g = granted source); other sources' tready = 0.
  - An accepted beat loads the output register (data, keep, sop, eop, valid=1) in the next cycle.
  - Latency is 1 cycle from source acceptance to m_axis_tx_tvalid.
- Output stage:
  - out_valid clears when m_axis_tx_tvalid && m_axis_tx_tready and no new beat is loaded that cycle.
  - Load and drain in the same cycle keeps valid=1 with the new beat, giving full throughput within a packet.
  - m_axis_tx_* stay stable while tvalid && !tready.
- End of packet: an accepted beat with eop=1 returns the arbiter to IDLE next cycle and sets grant=0. A single-beat TLP (sop=eop=1) is legal.
- Mid-packet sop: a beat from the granted source with sop=1 after the first beat is forwarded unchanged. The arbiter does not re-arbitrate.
- Orphan drain: in IDLE, a source with tvalid && !sop gets tready=1 for that beat. The beat is discarded, not forwarded, and err_orphan is set. err_orphan clears only on rst.
- Simultaneous events:
  - An eop acceptance and a new request in the same cycle: the request is served after the IDLE bubble.
  - A request arriving while BUSY waits; it is not lost provided the source holds tvalid (AXIS rule).
- Link stall: m_axis_tx_tready=0 holds the granted source at tready=0 once the output register is full, and state stays BUSY.

Test Plan:
- Single wr 3-beat TLP, m_tready=1 → 1 idle cycle, then the 3 beats appear on m_axis_tx in order with latency 1. sop appears on beat 0 and eop on beat 2. grant=3'b010 during the packet, then 0.
- CPL_PRIO=0, all three sources holding a 1-beat TLP continuously, pointer=cpl after reset → output order cpl,wr,rd,cpl,wr,rd, with one bubble between packets.
- CPL_PRIO=1, wr and rd requesting and cpl requesting every packet → cpl wins every arbitration; wr and rd alternate only when cpl is idle.
- Granted 4-beat rd TLP with m_tready toggling 1,0,0,1,1,1 → no beat dropped or duplicated. Output stays stable during stalls. s_rd_tready=0 while the output register is full and the link is stalled.
- Orphan: wr presents tvalid=1, sop=0, data 0xA5.. in IDLE → beat consumed, nothing on m_axis_tx, err_orphan=1 and held through subsequent traffic until rst.
- Assert rst during beat 2 of a 4-beat cpl TLP → next cycle all outputs are 0, grant=0, and the pointer is at cpl. A fresh wr TLP afterwards is arbitrated normally.
